// File: rtl/timer_pkg.sv
// Shared widths and shadow-register type for the timer count unit.
// Width defaults are exported so the interface, prescaler and top agree on operand sizes.
package timer_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_PSC_WIDTH = 16;
   localparam int DEF_DT_WIDTH  = 8;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] preload;
      logic [DEF_WIDTH-1:0] active;
   } shadow_reg_t;

   // A write is always captured in preload; active takes it at once when unbuffered or when it
   // coincides with an update event (bypass), otherwise active copies preload on the update event.
   function automatic shadow_reg_t shadow_next(
      input shadow_reg_t          cur,
      input logic                 wr,
      input logic [DEF_WIDTH-1:0] wdata,
      input logic                 preload_en,
      input logic                 uev
   );
      shadow_reg_t nxt;
      nxt = cur;
      if (wr) nxt.preload = wdata;
      if (wr && (!preload_en || uev)) nxt.active = wdata;
      else if (uev)                   nxt.active = cur.preload;
      return nxt;
   endfunction

endpackage

// File: rtl/timer_count_unit_if.sv
// Register-write and operand bus of the timer count unit.
// Strobes are single-cycle and always accepted; there is no back-pressure on this bus.
interface timer_count_unit_if
   import timer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PSC_WIDTH = DEF_PSC_WIDTH,
   parameter int DT_WIDTH  = DEF_DT_WIDTH
);

   logic                 enable;
   logic                 preload_en;
   logic                 psc_wr;
   logic [PSC_WIDTH-1:0] psc_wdata;
   logic                 max_wr;
   logic                 cmp_wr;
   logic                 dt_wr;
   logic [WIDTH-1:0]     wdata;
   logic                 sw_update;
   logic                 flag_clr;

   logic [WIDTH-1:0]     count;
   logic [WIDTH-1:0]     compare;
   logic [WIDTH-1:0]     maxval;
   logic [DT_WIDTH-1:0]  value;
   logic                 update_evt;
   logic                 ovf_flag;

   modport master (
      output enable, preload_en, psc_wr, psc_wdata, max_wr, cmp_wr, dt_wr, wdata,
             sw_update, flag_clr,
      input  count, compare, maxval, value, update_evt, ovf_flag
   );

   modport slave (
      input  enable, preload_en, psc_wr, psc_wdata, max_wr, cmp_wr, dt_wr, wdata,
             sw_update, flag_clr,
      output count, compare, maxval, value, update_evt, ovf_flag
   );

endinterface

// File: rtl/timer_prescaler.sv
// Programmable prescaler: divides the enabled clock by (psc_active + 1) and emits tick.
// The divide ratio is shadowed, so with preload enabled it changes only on an update event.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PSC_WIDTH = DEF_PSC_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 preload_en,
   input  logic                 psc_wr,
   input  logic [PSC_WIDTH-1:0] psc_wdata,
   input  logic                 restart,
   input  logic                 uev,
   output logic                 tick
);

   logic [PSC_WIDTH-1:0] psc_cnt;
   logic [PSC_WIDTH-1:0] psc_pre;
   logic [PSC_WIDTH-1:0] psc_active;

   assign tick = run && (psc_cnt == psc_active);

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_cnt    <= '0;
         psc_pre    <= '0;
         psc_active <= '0;
      end else begin
         // A software update realigns the prescaler even while the counter is frozen.
         if (restart || tick) psc_cnt <= '0;
         else if (run)        psc_cnt <= psc_cnt + PSC_WIDTH'(1);

         if (psc_wr) psc_pre <= psc_wdata;
         if (psc_wr && (!preload_en || uev)) psc_active <= psc_wdata;
         else if (uev)                       psc_active <= psc_pre;
      end
   end

endmodule

// File: rtl/timer_count_unit.sv
// Timer time base: prescaled edge-aligned up-counter with auto-reload, shadowed PWM operands and
// a sticky overflow flag. Defining TIMER_ONE_PULSE_EN adds a one_pulse input (halt after overflow).
module timer_count_unit
   import timer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PSC_WIDTH = DEF_PSC_WIDTH,
   parameter int DT_WIDTH  = DEF_DT_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
`ifdef TIMER_ONE_PULSE_EN
   input  logic              one_pulse,
`endif
   timer_count_unit_if.slave bus
);

   logic [WIDTH-1:0]    count_q;
   shadow_reg_t         max_r;
   shadow_reg_t         cmp_r;
   logic [DT_WIDTH-1:0] dt_pre;
   logic [DT_WIDTH-1:0] dt_active;
   logic                evt_q;
   logic                flag_q;
   logic                run;
   logic                tick;
   logic                ovf;
   logic                uev;

`ifdef TIMER_ONE_PULSE_EN
   logic halted;

   // Halt persists until enable drops (re-arm on the next rise) or software forces an update.
   always_ff @(posedge clk) begin
      if (reset)                              halted <= 1'b0;
      else if (!bus.enable || bus.sw_update)  halted <= 1'b0;
      else if (ovf && one_pulse)              halted <= 1'b1;
   end

   assign run = bus.enable && !halted;
`else
   assign run = bus.enable;
`endif

   timer_prescaler #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .preload_en (bus.preload_en),
      .psc_wr     (bus.psc_wr),
      .psc_wdata  (bus.psc_wdata),
      .restart    (bus.sw_update),
      .uev        (uev),
      .tick       (tick)
   );

   // >= rather than == so a maxval lowered below the running count still wraps on the next tick.
   assign ovf = tick && (count_q >= max_r.active);
   assign uev = ovf || bus.sw_update;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         max_r     <= '0;
         cmp_r     <= '0;
         dt_pre    <= '0;
         dt_active <= '0;
         evt_q     <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         if (uev)       count_q <= '0;
         else if (tick) count_q <= count_q + WIDTH'(1);

         max_r <= shadow_next(max_r, bus.max_wr, bus.wdata, bus.preload_en, uev);
         cmp_r <= shadow_next(cmp_r, bus.cmp_wr, bus.wdata, bus.preload_en, uev);

         if (bus.dt_wr) dt_pre <= bus.wdata[DT_WIDTH-1:0];
         if (bus.dt_wr && (!bus.preload_en || uev)) dt_active <= bus.wdata[DT_WIDTH-1:0];
         else if (uev)                              dt_active <= dt_pre;

         evt_q  <= uev;
         flag_q <= uev || (flag_q && !bus.flag_clr);
      end
   end

   assign bus.count      = count_q;
   assign bus.compare    = cmp_r.active;
   assign bus.maxval     = max_r.active;
   assign bus.value      = dt_active;
   assign bus.update_evt = evt_q;
   assign bus.ovf_flag   = flag_q;

endmodule

// File: tb/tb_timer_count_unit.sv
// Bench for timer_count_unit: directed scenarios plus randomized traffic, all checked against a
// cycle-level reference model through an expected-value queue.
module tb_timer_count_unit;
   import timer_pkg::*;

   localparam int W = 3 * DEF_WIDTH + DEF_DT_WIDTH + 2;

   logic clk;
   logic reset;
`ifdef TIMER_ONE_PULSE_EN
   logic one_pulse;
`endif

   timer_count_unit_if bus ();

   timer_count_unit dut (
      .clk       (clk),
      .reset     (reset),
`ifdef TIMER_ONE_PULSE_EN
      .one_pulse (one_pulse),
`endif
      .bus       (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Index 0 prescaler, 1 maxval, 2 compare, 3 dead-time.
   logic [31:0] m_count, m_psc_cnt;
   logic [31:0] m_pre[4];
   logic [31:0] m_act[4];
   bit          m_evt, m_flag, m_halted;

   function automatic void model_step();
      bit          wr[4];
      logic [31:0] d[4];
      bit          running, tick, ovf, uev;
      if (reset) begin
         m_count = 0; m_psc_cnt = 0; m_evt = 0; m_flag = 0; m_halted = 0;
         for (int i = 0; i < 4; i++) begin m_pre[i] = 0; m_act[i] = 0; end
      end else begin
         wr = '{bus.psc_wr, bus.max_wr, bus.cmp_wr, bus.dt_wr};
         d  = '{32'(bus.psc_wdata), bus.wdata, bus.wdata, 32'(bus.wdata[DEF_DT_WIDTH-1:0])};
         running = bus.enable && !m_halted;
         tick    = running && (m_psc_cnt == m_act[0]);
         ovf     = tick && (m_count >= m_act[1]);
         uev     = ovf || bus.sw_update;
         if (bus.sw_update) begin
            m_count = 0; m_psc_cnt = 0;
         end else if (tick) begin
            m_psc_cnt = 0;
            m_count   = ovf ? 32'd0 : m_count + 32'd1;
         end else if (running) begin
            m_psc_cnt = m_psc_cnt + 32'd1;
         end
`ifdef TIMER_ONE_PULSE_EN
         if (!bus.enable || bus.sw_update) m_halted = 0;
         else if (ovf && one_pulse)        m_halted = 1;
`endif
         for (int i = 0; i < 4; i++) begin
            if (wr[i] && (!bus.preload_en || uev)) m_act[i] = d[i];
            else if (uev)                          m_act[i] = m_pre[i];
            if (wr[i]) m_pre[i] = d[i];
         end
         m_evt  = uev;
         m_flag = uev || (m_flag && !bus.flag_clr);
      end
      exp_q.push_back({m_count, m_act[2], m_act[1], m_act[3][DEF_DT_WIDTH-1:0], m_evt, m_flag});
   endfunction

   task automatic compare_outputs();
      logic [W-1:0] e;
      check("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("count",      64'(bus.count),      64'(e[W-1 -: DEF_WIDTH]));
      check("compare",    64'(bus.compare),    64'(e[W-1-DEF_WIDTH -: DEF_WIDTH]));
      check("maxval",     64'(bus.maxval),     64'(e[W-1-2*DEF_WIDTH -: DEF_WIDTH]));
      check("value",      64'(bus.value),      64'(e[DEF_DT_WIDTH+1:2]));
      check("update_evt", 64'(bus.update_evt), 64'(e[1]));
      check("ovf_flag",   64'(bus.ovf_flag),   64'(e[0]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      compare_outputs();
   endtask

   task automatic set_idle();
      bus.psc_wr = 0; bus.psc_wdata = '0; bus.max_wr = 0; bus.cmp_wr = 0; bus.dt_wr = 0;
      bus.wdata = '0; bus.sw_update = 0; bus.flag_clr = 0;
   endtask

   task automatic write_max(input logic [31:0] v);
      bus.max_wr = 1; bus.wdata = v; step(); set_idle();
   endtask

   task automatic write_cmp(input logic [31:0] v);
      bus.cmp_wr = 1; bus.wdata = v; step(); set_idle();
   endtask

   task automatic write_psc(input logic [15:0] v);
      bus.psc_wr = 1; bus.psc_wdata = v; step(); set_idle();
   endtask

   task automatic sw_update();
      bus.sw_update = 1; step(); set_idle();
   endtask

   // ---------------- test sequence ----------------
   int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
   int first_evt, n;

   initial begin
      reset = 1;
`ifdef TIMER_ONE_PULSE_EN
      one_pulse = 0;
`endif
      set_idle();
      bus.enable = 0; bus.preload_en = 0;
      #1;
      step(); step();
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_compare", 64'(bus.compare), 64'd0);
      check("rst_maxval", 64'(bus.maxval), 64'd0);
      check("rst_value", 64'(bus.value), 64'd0);
      check("rst_evt", 64'(bus.update_evt), 64'd0);
      check("rst_flag", 64'(bus.ovf_flag), 64'd0);
      reset = 0;

      // psc 0, maxval 4: 0,1,2,3,4,0
      write_psc(16'd0);
      write_max(32'd4);
      sw_update();
      check("seq0", 64'(bus.count), 64'(exp_seq[0]));
      bus.enable = 1;
      for (int i = 1; i < 6; i++) begin
         step();
         check("seq", 64'(bus.count), 64'(exp_seq[i]));
      end
      check("wrap_evt", 64'(bus.update_evt), 64'd1);
      check("wrap_flag", 64'(bus.ovf_flag), 64'd1);

      // psc 2, maxval 3: update period 12 clocks
      bus.enable = 0;
      write_psc(16'd2);
      write_max(32'd3);
      sw_update();
      first_evt = cyc;
      bus.enable = 1;
      n = 0;
      step();
      while (bus.update_evt !== 1'b1 && n < 40) begin step(); n++; end
      check("uev_period", 64'(cyc - first_evt), 64'd12);

      // preload: outputs hold until the wrap past 9
      bus.enable = 0;
      write_psc(16'd0);
      write_max(32'd9);
      write_cmp(32'd1);
      sw_update();
      bus.enable = 1; bus.preload_en = 1;
      step(); step();
      check("pl_count", 64'(bus.count), 64'd2);
      write_cmp(32'd7);
      write_max(32'd5);
      check("pl_cmp_hold", 64'(bus.compare), 64'd1);
      check("pl_max_hold", 64'(bus.maxval), 64'd9);
      n = 0;
      while (bus.update_evt !== 1'b1 && n < 30) begin step(); n++; end
      check("pl_wait_uev", 64'(bus.update_evt), 64'd1);
      check("pl_cmp_new", 64'(bus.compare), 64'd7);
      check("pl_max_new", 64'(bus.maxval), 64'd5);
      for (int i = 0; i < 8; i++) step();

      // immediate writes
      bus.preload_en = 0;
      write_cmp(32'd3);
      check("imm_cmp", 64'(bus.compare), 64'd3);
      write_max(32'd2);
      check("imm_max", 64'(bus.maxval), 64'd2);
      for (int i = 0; i < 6; i++) step();

      // write and software update together: bypass
      bus.preload_en = 1;
      bus.max_wr = 1; bus.wdata = 32'd6; bus.sw_update = 1;
      step(); set_idle();
      check("byp_max", 64'(bus.maxval), 64'd6);
      check("byp_count", 64'(bus.count), 64'd0);
      check("byp_evt", 64'(bus.update_evt), 64'd1);

      // flag: set beats clear, then clear alone
      bus.enable = 0;
      bus.flag_clr = 1; bus.sw_update = 1; step(); set_idle();
      check("flag_set_wins", 64'(bus.ovf_flag), 64'd1);
      bus.flag_clr = 1; step(); set_idle();
      check("flag_clr", 64'(bus.ovf_flag), 64'd0);
      bus.preload_en = 0;
      write_max(32'd0);
      bus.enable = 1; bus.flag_clr = 1;
      step(); step();
      check("flag_ovf_clr", 64'(bus.ovf_flag), 64'd1);
      check("max0_count", 64'(bus.count), 64'd0);
      set_idle();

`ifdef TIMER_ONE_PULSE_EN
      bus.enable = 0;
      write_max(32'd3);
      sw_update();
      one_pulse = 1; bus.enable = 1;
      for (int i = 0; i < 8; i++) step();
      check("op_rest", 64'(bus.count), 64'd0);
      check("op_quiet", 64'(bus.update_evt), 64'd0);
      bus.enable = 0; step();
      bus.enable = 1; step(); step();
      check("op_restart", 64'(bus.count), 64'd2);
      one_pulse = 0;
`endif

      // reset in mid-period
      bus.enable = 1;
      write_max(32'd9);
      step(); step();
      reset = 1; step(); reset = 0;
      check("midrst_count", 64'(bus.count), 64'd0);
      check("midrst_evt", 64'(bus.update_evt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 299) == 0);
         bus.enable     = ($urandom_range(0, 9) != 0);
         bus.preload_en = 1'($urandom_range(0, 1));
         bus.psc_wr     = ($urandom_range(0, 15) == 0);
         bus.psc_wdata  = 16'($urandom_range(0, 3));
         bus.max_wr     = ($urandom_range(0, 11) == 0);
         bus.cmp_wr     = ($urandom_range(0, 11) == 0);
         bus.dt_wr      = ($urandom_range(0, 11) == 0);
         bus.wdata      = ($urandom_range(0, 15) == 0) ? $urandom() : $urandom_range(0, 15);
         bus.sw_update  = ($urandom_range(0, 39) == 0);
         bus.flag_clr   = ($urandom_range(0, 9) == 0);
`ifdef TIMER_ONE_PULSE_EN
         one_pulse      = ($urandom_range(0, 7) == 0);
`endif
         step();
      end
      reset = 0;
      set_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
